// File: rtl/tl_arb_pkg.sv
// Shared types and helpers for the TileLink A-channel arbiter.
package tl_arb_pkg;

    // TL-UH A-channel opcodes the arbiter cares about
    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;

    // log2 of the beat width in bytes (64-bit beats) and the largest size handled
    localparam logic [2:0] LG_BEAT_BYTES = 3'd3;
    localparam logic [2:0] MAX_SIZE      = 3'd6;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        BURST
    } state_e;

    // Number of A beats carried by a message; only Puts larger than a beat span several
    function automatic logic [3:0] beats_of(input logic [2:0] opcode, input logic [2:0] size);
        logic [2:0] sz;
        sz = (size > MAX_SIZE) ? MAX_SIZE : size;
        if ((opcode == OP_PUT_FULL || opcode == OP_PUT_PARTIAL) && sz > LG_BEAT_BYTES)
            return 4'd1 << (sz - LG_BEAT_BYTES);
        return 4'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester after last_i, wrapping.
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     valid_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int unsigned last_u;

    // Scan indices above last_i first, then wrap to those at or below it
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        last_u  = 32'(last_i);
        for (int unsigned c = 0; c < N; c++) begin
            if (valid_i[c] && c > last_u && !any_o) begin
                any_o      = 1'b1;
                grant_o[c] = 1'b1;
                idx_o      = IDX_W'(c);
            end
        end
        for (int unsigned c = 0; c < N; c++) begin
            if (valid_i[c] && c <= last_u && !any_o) begin
                any_o      = 1'b1;
                grant_o[c] = 1'b1;
                idx_o      = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/tl_a_channel_arbiter.sv
// Shares one TL-UH master port among NUM_IN requesters: round-robin A arbitration
// with grant lock across stalls and multi-beat Puts, D routed by source prefix.
module tl_a_channel_arbiter
    import tl_arb_pkg::*;
#(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SRC_W  = 5,
    parameter int unsigned ADDR_W = 25,
    parameter int unsigned DATA_W = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_IN-1:0]            in_a_valid,
    output logic [NUM_IN-1:0]            in_a_ready,
    input  logic [NUM_IN*3-1:0]          in_a_opcode,
    input  logic [NUM_IN*3-1:0]          in_a_param,
    input  logic [NUM_IN*3-1:0]          in_a_size,
    input  logic [NUM_IN*SRC_W-1:0]      in_a_source,
    input  logic [NUM_IN*ADDR_W-1:0]     in_a_address,
    input  logic [NUM_IN*(DATA_W/8)-1:0] in_a_mask,
    input  logic [NUM_IN*DATA_W-1:0]     in_a_data,
    output logic                         out_a_valid,
    input  logic                         out_a_ready,
    output logic [2:0]                   out_a_opcode,
    output logic [2:0]                   out_a_param,
    output logic [2:0]                   out_a_size,
    output logic [SRC_W+1:0]             out_a_source,
    output logic [ADDR_W-1:0]            out_a_address,
    output logic [DATA_W/8-1:0]          out_a_mask,
    output logic [DATA_W-1:0]            out_a_data,
    input  logic                         out_d_valid,
    output logic                         out_d_ready,
    input  logic [SRC_W+1:0]             out_d_source,
    output logic [NUM_IN-1:0]            in_d_valid,
    input  logic [NUM_IN-1:0]            in_d_ready,
    output logic [SRC_W-1:0]             in_d_source,
    output logic                         d_route_err
);

    localparam int unsigned IDX_W = 2;
    localparam int unsigned MW    = DATA_W / 8;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [2:0]         beats_q, beats_d;
    logic               derr_q, derr_d;

    logic [NUM_IN-1:0]  pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [IDX_W-1:0]   act_idx;
    logic               req_valid;
    logic               fire;
    logic [3:0]         beats;
    logic [3:0]         beats_m1;
    logic [SRC_W-1:0]   req_source;
    logic [IDX_W-1:0]   d_idx;
    logic               d_hit;

    rr_pick #(.N(NUM_IN), .IDX_W(IDX_W)) u_pick (
        .valid_i (in_a_valid),
        .last_i  (last_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // A datapath: mux the active requester onto the master port, forced idle in reset
    always_comb begin
        act_idx       = (state_q == IDLE) ? pick_idx : grant_q;
        req_valid     = 1'b0;
        req_source    = '0;
        out_a_opcode  = '0;
        out_a_param   = '0;
        out_a_size    = '0;
        out_a_address = '0;
        out_a_mask    = '0;
        out_a_data    = '0;
        in_a_ready    = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (act_idx == IDX_W'(i)) begin
                req_valid     = in_a_valid[i];
                out_a_opcode  = in_a_opcode[i*3 +: 3];
                out_a_param   = in_a_param[i*3 +: 3];
                out_a_size    = in_a_size[i*3 +: 3];
                req_source    = in_a_source[i*SRC_W +: SRC_W];
                out_a_address = in_a_address[i*ADDR_W +: ADDR_W];
                out_a_mask    = in_a_mask[i*MW +: MW];
                out_a_data    = in_a_data[i*DATA_W +: DATA_W];
                if (state_q != IDLE)
                    in_a_ready[i] = out_a_ready;
            end
        end
        if (state_q == IDLE)
            in_a_ready = pick_grant & {NUM_IN{out_a_ready}};
        out_a_valid  = (state_q == IDLE) ? pick_any : req_valid;
        out_a_source = {act_idx, req_source};
        if (reset) begin
            out_a_valid = 1'b0;
            in_a_ready  = '0;
        end
        fire     = out_a_valid & out_a_ready;
        beats    = beats_of(out_a_opcode, out_a_size);
        beats_m1 = beats - 4'd1;
    end

    // Grant FSM: lock through a stalled first beat and through every Put beat
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        beats_d = beats_q;
        unique case (state_q)
            IDLE: begin
                grant_d = pick_idx;
                if (pick_any) begin
                    if (!fire) begin
                        state_d = HOLD;
                    end else if (beats != 4'd1) begin
                        state_d = BURST;
                        beats_d = beats_m1[2:0];
                    end else begin
                        last_d = pick_idx;
                    end
                end
            end
            HOLD: begin
                if (fire) begin
                    if (beats != 4'd1) begin
                        state_d = BURST;
                        beats_d = beats_m1[2:0];
                    end else begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end
                end
            end
            BURST: begin
                if (fire) begin
                    if (beats_q == 3'd1) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end
                    beats_d = beats_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // D routing by the source prefix; unknown prefixes are drained and flagged
    always_comb begin
        d_idx       = out_d_source[SRC_W+1:SRC_W];
        d_hit       = 1'b0;
        in_d_valid  = '0;
        out_d_ready = 1'b0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (d_idx == IDX_W'(i)) begin
                d_hit         = 1'b1;
                in_d_valid[i] = out_d_valid;
                out_d_ready   = in_d_ready[i];
            end
        end
        if (!d_hit)
            out_d_ready = 1'b1;
        derr_d = out_d_valid & ~d_hit;
        if (reset) begin
            in_d_valid  = '0;
            out_d_ready = 1'b0;
        end
    end

    assign in_d_source = out_d_source[SRC_W-1:0];
    assign d_route_err = derr_q;

    // State registers; last grant resets to the top index so port 0 wins first
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(NUM_IN - 1);
            grant_q <= '0;
            beats_q <= '0;
            derr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            beats_q <= beats_d;
            derr_q  <= derr_d;
        end
    end

endmodule

// File: tb/tb_tl_a_channel_arbiter.sv
// Directed testbench for tl_a_channel_arbiter (4-port instance plus a 3-port one for D errors).
module tb_tl_a_channel_arbiter;
    import tl_arb_pkg::*;

    logic        clock = 1'b0;
    logic        reset;

    // 4-port instance
    logic [3:0]   in_a_valid, in_a_ready;
    logic [11:0]  in_a_opcode, in_a_param, in_a_size;
    logic [19:0]  in_a_source;
    logic [99:0]  in_a_address;
    logic [31:0]  in_a_mask;
    logic [255:0] in_a_data;
    logic         out_a_valid, out_a_ready;
    logic [2:0]   out_a_opcode, out_a_param, out_a_size;
    logic [6:0]   out_a_source;
    logic [24:0]  out_a_address;
    logic [7:0]   out_a_mask;
    logic [63:0]  out_a_data;
    logic         out_d_valid, out_d_ready;
    logic [6:0]   out_d_source;
    logic [3:0]   in_d_valid, in_d_ready;
    logic [4:0]   in_d_source;
    logic         d_route_err;

    // 3-port instance
    logic [2:0]   b_in_a_valid, b_in_a_ready;
    logic [8:0]   b_in_a_opcode, b_in_a_param, b_in_a_size;
    logic [14:0]  b_in_a_source;
    logic [74:0]  b_in_a_address;
    logic [23:0]  b_in_a_mask;
    logic [191:0] b_in_a_data;
    logic         b_out_a_valid, b_out_a_ready;
    logic [2:0]   b_out_a_opcode, b_out_a_param, b_out_a_size;
    logic [6:0]   b_out_a_source;
    logic [24:0]  b_out_a_address;
    logic [7:0]   b_out_a_mask;
    logic [63:0]  b_out_a_data;
    logic         b_out_d_valid, b_out_d_ready;
    logic [6:0]   b_out_d_source;
    logic [2:0]   b_in_d_valid, b_in_d_ready;
    logic [4:0]   b_in_d_source;
    logic         b_d_route_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    tl_a_channel_arbiter #(.NUM_IN(4), .SRC_W(5), .ADDR_W(25), .DATA_W(64)) dut (
        .clock(clock), .reset(reset),
        .in_a_valid(in_a_valid), .in_a_ready(in_a_ready),
        .in_a_opcode(in_a_opcode), .in_a_param(in_a_param), .in_a_size(in_a_size),
        .in_a_source(in_a_source), .in_a_address(in_a_address),
        .in_a_mask(in_a_mask), .in_a_data(in_a_data),
        .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
        .out_a_opcode(out_a_opcode), .out_a_param(out_a_param), .out_a_size(out_a_size),
        .out_a_source(out_a_source), .out_a_address(out_a_address),
        .out_a_mask(out_a_mask), .out_a_data(out_a_data),
        .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_source(out_d_source),
        .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_source(in_d_source),
        .d_route_err(d_route_err)
    );

    tl_a_channel_arbiter #(.NUM_IN(3), .SRC_W(5), .ADDR_W(25), .DATA_W(64)) dut3 (
        .clock(clock), .reset(reset),
        .in_a_valid(b_in_a_valid), .in_a_ready(b_in_a_ready),
        .in_a_opcode(b_in_a_opcode), .in_a_param(b_in_a_param), .in_a_size(b_in_a_size),
        .in_a_source(b_in_a_source), .in_a_address(b_in_a_address),
        .in_a_mask(b_in_a_mask), .in_a_data(b_in_a_data),
        .out_a_valid(b_out_a_valid), .out_a_ready(b_out_a_ready),
        .out_a_opcode(b_out_a_opcode), .out_a_param(b_out_a_param), .out_a_size(b_out_a_size),
        .out_a_source(b_out_a_source), .out_a_address(b_out_a_address),
        .out_a_mask(b_out_a_mask), .out_a_data(b_out_a_data),
        .out_d_valid(b_out_d_valid), .out_d_ready(b_out_d_ready), .out_d_source(b_out_d_source),
        .in_d_valid(b_in_d_valid), .in_d_ready(b_in_d_ready), .in_d_source(b_in_d_source),
        .d_route_err(b_d_route_err)
    );

    task automatic set_req(input int p, input logic v, input logic [2:0] op, input logic [2:0] sz,
                           input logic [4:0] src, input logic [24:0] addr, input logic [63:0] data);
        in_a_valid[p]            = v;
        in_a_opcode[p*3 +: 3]    = op;
        in_a_param[p*3 +: 3]     = 3'd0;
        in_a_size[p*3 +: 3]      = sz;
        in_a_source[p*5 +: 5]    = src;
        in_a_address[p*25 +: 25] = addr;
        in_a_mask[p*8 +: 8]      = 8'hF0 | 8'(p);
        in_a_data[p*64 +: 64]    = data;
    endtask

    task automatic clear_inputs();
        in_a_valid = '0; in_a_opcode = '0; in_a_param = '0; in_a_size = '0;
        in_a_source = '0; in_a_address = '0; in_a_mask = '0; in_a_data = '0;
        out_a_ready = 1'b0; out_d_valid = 1'b0; out_d_source = '0; in_d_ready = '0;
        b_in_a_valid = '0; b_in_a_opcode = '0; b_in_a_param = '0; b_in_a_size = '0;
        b_in_a_source = '0; b_in_a_address = '0; b_in_a_mask = '0; b_in_a_data = '0;
        b_out_a_ready = 1'b0; b_out_d_valid = 1'b0; b_out_d_source = '0; b_in_d_ready = '0;
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset released
    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        in_a_valid = 4'b1111; out_a_ready = 1'b1; out_d_valid = 1'b1;
        out_d_source = 7'h45; in_d_ready = 4'b1111;
        b_out_d_valid = 1'b1; b_out_d_source = 7'h63;
        repeat (2) @(posedge clock);
        #4;
        n_cmp++; if (out_a_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_a_valid: got %b expected 0", out_a_valid); end
        n_cmp++; if (in_a_ready !== 4'b0000) begin n_err++; $display("FAIL reset_in_a_ready: got %b expected 0000", in_a_ready); end
        n_cmp++; if (in_d_valid !== 4'b0000) begin n_err++; $display("FAIL reset_in_d_valid: got %b expected 0000", in_d_valid); end
        n_cmp++; if (out_d_ready !== 1'b0) begin n_err++; $display("FAIL reset_out_d_ready: got %b expected 0", out_d_ready); end
        n_cmp++; if (d_route_err !== 1'b0) begin n_err++; $display("FAIL reset_d_route_err: got %b expected 0", d_route_err); end
        n_cmp++; if (b_out_d_ready !== 1'b0) begin n_err++; $display("FAIL reset_b_out_d_ready: got %b expected 0", b_out_d_ready); end
        do_reset();
    endtask

    task automatic test_rr_get();
        do_reset();
        out_a_ready = 1'b1;
        set_req(0, 1'b1, OP_GET, 3'd3, 5'h03, 25'h0000100, 64'h0);
        set_req(2, 1'b1, OP_GET, 3'd3, 5'h11, 25'h0000200, 64'h0);
        #3;
        n_cmp++; if (out_a_valid !== 1'b1) begin n_err++; $display("FAIL rr_c0_valid: got %b expected 1", out_a_valid); end
        n_cmp++; if (out_a_source !== 7'h03) begin n_err++; $display("FAIL rr_c0_source: got %h expected 03", out_a_source); end
        n_cmp++; if (out_a_address !== 25'h0000100) begin n_err++; $display("FAIL rr_c0_address: got %h expected 0000100", out_a_address); end
        n_cmp++; if (out_a_mask !== 8'hF0) begin n_err++; $display("FAIL rr_c0_mask: got %h expected f0", out_a_mask); end
        n_cmp++; if (in_a_ready !== 4'b0001) begin n_err++; $display("FAIL rr_c0_ready: got %b expected 0001", in_a_ready); end
        next_cycle();
        in_a_valid[0] = 1'b0;
        #3;
        n_cmp++; if (out_a_source !== 7'h51) begin n_err++; $display("FAIL rr_c1_source: got %h expected 51", out_a_source); end
        n_cmp++; if (in_a_ready !== 4'b0100) begin n_err++; $display("FAIL rr_c1_ready: got %b expected 0100", in_a_ready); end
        n_cmp++; if (out_a_size !== 3'd3 || out_a_opcode !== OP_GET) begin n_err++; $display("FAIL rr_c1_fields: got op %0d size %0d expected op 4 size 3", out_a_opcode, out_a_size); end
        next_cycle();
        in_a_valid[2] = 1'b0;
        #3;
        n_cmp++; if (out_a_valid !== 1'b0) begin n_err++; $display("FAIL rr_c2_idle: got %b expected 0", out_a_valid); end
    endtask

    task automatic test_burst();
        logic [63:0] d;
        logic        v;
        int          beat;
        do_reset();
        out_a_ready = 1'b1;
        set_req(3, 1'b1, OP_GET, 3'd3, 5'h1F, 25'h1000000, 64'h0);
        beat = 0;
        // cycle 2 drops port 1 valid: the burst must stall, not release
        for (int c = 0; c < 5; c++) begin
            v = (c != 2);
            d = 64'hD0D0_0000_0000_0000 | 64'(beat);
            set_req(1, v, OP_PUT_FULL, 3'd5, 5'h0A, 25'h0000040, d);
            #3;
            if (v) begin
                n_cmp++; if (out_a_valid !== 1'b1 || out_a_source !== 7'h2A) begin n_err++; $display("FAIL burst_src beat %0d: got v%b %h expected v1 2a", beat, out_a_valid, out_a_source); end
                n_cmp++; if (out_a_data !== d) begin n_err++; $display("FAIL burst_data beat %0d: got %h expected %h", beat, out_a_data, d); end
                beat++;
            end else begin
                n_cmp++; if (out_a_valid !== 1'b0) begin n_err++; $display("FAIL burst_stall_valid: got %b expected 0", out_a_valid); end
            end
            n_cmp++; if (in_a_ready[3] !== 1'b0) begin n_err++; $display("FAIL burst_port3_ready cycle %0d: got %b expected 0", c, in_a_ready[3]); end
            next_cycle();
        end
        in_a_valid[1] = 1'b0;
        #3;
        n_cmp++; if (out_a_source !== 7'h7F) begin n_err++; $display("FAIL burst_after_src: got %h expected 7f", out_a_source); end
        n_cmp++; if (in_a_ready !== 4'b1000) begin n_err++; $display("FAIL burst_after_ready: got %b expected 1000", in_a_ready); end
        next_cycle();
        in_a_valid[3] = 1'b0;
    endtask

    task automatic test_hold();
        do_reset();
        set_req(0, 1'b1, OP_GET, 3'd3, 5'h02, 25'h0123456, 64'h0);
        for (int c = 0; c < 6; c++) begin
            if (c == 2) set_req(1, 1'b1, OP_GET, 3'd2, 5'h07, 25'h1ABCDEF, 64'h0);
            out_a_ready = (c == 5);
            #3;
            n_cmp++; if (out_a_source !== 7'h02 || out_a_address !== 25'h0123456) begin n_err++; $display("FAIL hold_c%0d: got %h/%h expected 02/0123456", c, out_a_source, out_a_address); end
            n_cmp++; if (in_a_ready !== (c == 5 ? 4'b0001 : 4'b0000)) begin n_err++; $display("FAIL hold_ready_c%0d: got %b", c, in_a_ready); end
            next_cycle();
        end
        in_a_valid[0] = 1'b0;
        #3;
        n_cmp++; if (out_a_source !== 7'h27 || out_a_address !== 25'h1ABCDEF) begin n_err++; $display("FAIL hold_next: got %h/%h expected 27/1abcdef", out_a_source, out_a_address); end
        next_cycle();
        in_a_valid[1] = 1'b0;
        // last grant is now 1: stall port 3, then port 2 arrives; IDLE would prefer 2
        out_a_ready = 1'b0;
        set_req(3, 1'b1, OP_GET, 3'd3, 5'h04, 25'h0000300, 64'h0);
        next_cycle();
        set_req(2, 1'b1, OP_GET, 3'd3, 5'h05, 25'h0000200, 64'h0);
        #3;
        n_cmp++; if (out_a_source !== 7'h64) begin n_err++; $display("FAIL hold_lock: got %h expected 64", out_a_source); end
        out_a_ready = 1'b1;
        next_cycle();
        in_a_valid[3] = 1'b0;
        #3;
        n_cmp++; if (out_a_source !== 7'h45) begin n_err++; $display("FAIL hold_lock_next: got %h expected 45", out_a_source); end
        next_cycle();
        in_a_valid[2] = 1'b0;
        out_a_ready = 1'b0;
    endtask

    task automatic test_d_route();
        do_reset();
        out_d_valid = 1'b1; out_d_source = 7'h45; in_d_ready = 4'b0100;
        #3;
        n_cmp++; if (in_d_valid !== 4'b0100) begin n_err++; $display("FAIL d_valid_idx2: got %b expected 0100", in_d_valid); end
        n_cmp++; if (in_d_source !== 5'd5) begin n_err++; $display("FAIL d_source_idx2: got %h expected 05", in_d_source); end
        n_cmp++; if (out_d_ready !== 1'b1) begin n_err++; $display("FAIL d_ready_idx2_hi: got %b expected 1", out_d_ready); end
        in_d_ready = 4'b1011;
        #1;
        n_cmp++; if (out_d_ready !== 1'b0) begin n_err++; $display("FAIL d_ready_idx2_lo: got %b expected 0", out_d_ready); end
        out_d_source = 7'h1F; in_d_ready = 4'b0001;
        #1;
        n_cmp++; if (in_d_valid !== 4'b0001 || in_d_source !== 5'h1F || out_d_ready !== 1'b1) begin n_err++; $display("FAIL d_idx0: got %b/%h/%b expected 0001/1f/1", in_d_valid, in_d_source, out_d_ready); end
        next_cycle();
        out_d_valid = 1'b0;
        #3;
        n_cmp++; if (d_route_err !== 1'b0) begin n_err++; $display("FAIL d_no_err: got %b expected 0", d_route_err); end
    endtask

    task automatic test_route_err();
        do_reset();
        b_out_d_valid = 1'b1; b_out_d_source = 7'h63; b_in_d_ready = 3'b000;
        #3;
        n_cmp++; if (b_in_d_valid !== 3'b000) begin n_err++; $display("FAIL err_d_valid: got %b expected 000", b_in_d_valid); end
        n_cmp++; if (b_out_d_ready !== 1'b1) begin n_err++; $display("FAIL err_d_ready: got %b expected 1", b_out_d_ready); end
        n_cmp++; if (b_d_route_err !== 1'b0) begin n_err++; $display("FAIL err_early: got %b expected 0", b_d_route_err); end
        next_cycle();
        b_out_d_valid = 1'b0;
        #3;
        n_cmp++; if (b_d_route_err !== 1'b1) begin n_err++; $display("FAIL err_pulse: got %b expected 1", b_d_route_err); end
        next_cycle();
        #3;
        n_cmp++; if (b_d_route_err !== 1'b0) begin n_err++; $display("FAIL err_pulse_end: got %b expected 0", b_d_route_err); end
        b_out_d_valid = 1'b1; b_out_d_source = 7'h45; b_in_d_ready = 3'b100;
        #1;
        n_cmp++; if (b_in_d_valid !== 3'b100 || b_out_d_ready !== 1'b1) begin n_err++; $display("FAIL err_valid_idx2: got %b/%b expected 100/1", b_in_d_valid, b_out_d_ready); end
        next_cycle();
        b_out_d_valid = 1'b0;
        #3;
        n_cmp++; if (b_d_route_err !== 1'b0) begin n_err++; $display("FAIL err_valid_no_pulse: got %b expected 0", b_d_route_err); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        out_a_ready = 1'b1;
        set_req(0, 1'b1, OP_PUT_PARTIAL, 3'd6, 5'h01, 25'h0000080, 64'h1111);
        set_req(1, 1'b1, OP_GET, 3'd3, 5'h04, 25'h0000400, 64'h0);
        next_cycle();
        next_cycle();
        reset = 1'b1;
        #1;
        n_cmp++; if (out_a_valid !== 1'b0 || in_a_ready !== 4'b0000) begin n_err++; $display("FAIL rst_mid_outputs: got v%b r%b expected v0 r0000", out_a_valid, in_a_ready); end
        set_req(0, 1'b1, OP_GET, 3'd3, 5'h09, 25'h0000090, 64'h0);
        #1 reset = 1'b0;
        #1;
        n_cmp++; if (out_a_source !== 7'h09 || in_a_ready !== 4'b0001) begin n_err++; $display("FAIL rst_mid_first: got %h/%b expected 09/0001", out_a_source, in_a_ready); end
        next_cycle();
        in_a_valid[0] = 1'b0;
        #3;
        n_cmp++; if (out_a_valid !== 1'b1 || out_a_source !== 7'h24) begin n_err++; $display("FAIL rst_mid_second: got v%b %h expected v1 24", out_a_valid, out_a_source); end
        next_cycle();
        in_a_valid[1] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rr_get();
        test_burst();
        test_hold();
        test_d_route();
        test_route_err();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
